// File: rtl/smm0_pkg.sv
// Shared types, element offsets and element-wise helpers for the 2x2 Strassen leaf.
// Matrices are four DATAWIDTH-bit elements packed row-major, e00 in the LSBs.
package smm0_pkg;

   localparam int DATAWIDTH = 32;

   localparam int E00 = 0;
   localparam int E01 = DATAWIDTH;
   localparam int E10 = 2 * DATAWIDTH;
   localparam int E11 = 3 * DATAWIDTH;

   typedef logic [DATAWIDTH-1:0]   elem_t;
   typedef logic [4*DATAWIDTH-1:0] mat_t;

   function automatic mat_t mat_pack(elem_t e00, elem_t e01, elem_t e10, elem_t e11);
      return {e11, e10, e01, e00};
   endfunction

   function automatic elem_t mat_el(mat_t m, int off);
      return m[off +: DATAWIDTH];
   endfunction

   // Each lane wraps on its own; no carry crosses an element boundary.
   function automatic mat_t mat_add(mat_t a, mat_t b);
      mat_t r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*DATAWIDTH +: DATAWIDTH] = a[i*DATAWIDTH +: DATAWIDTH] + b[i*DATAWIDTH +: DATAWIDTH];
      end
      return r;
   endfunction

   function automatic mat_t mat_sub(mat_t a, mat_t b);
      mat_t r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*DATAWIDTH +: DATAWIDTH] = a[i*DATAWIDTH +: DATAWIDTH] - b[i*DATAWIDTH +: DATAWIDTH];
      end
      return r;
   endfunction

endpackage

// File: rtl/smm0_elem_mul.sv
// Registered signed element multiplier keeping only the low DATAWIDTH product bits.
module smm0_elem_mul
   import smm0_pkg::*;
#(
   parameter int DATAWIDTH = smm0_pkg::DATAWIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DATAWIDTH-1:0] a_i,
   input  logic [DATAWIDTH-1:0] b_i,
   output logic [DATAWIDTH-1:0] p_o
);

   logic [DATAWIDTH-1:0] p_d;
   logic [DATAWIDTH-1:0] p_q;

   // A self-determined DATAWIDTH-wide product is exactly the truncated signed product.
   always_comb begin
      p_d = $signed(a_i) * $signed(b_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/smm0.sv
// 2x2 Strassen matrix multiply leaf: operand stage, 7 products, recombination, output.
// Load at edge k gives C_out after edge k+3; sel=1 multiplies A by column 0 of B.
module smm0
   import smm0_pkg::*;
#(
   parameter int DATAWIDTH = smm0_pkg::DATAWIDTH,
   parameter int BLOCKSIZE = DATAWIDTH * 4,
   parameter int BUSWIDTH  = BLOCKSIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BUSWIDTH-1:0] A,
   input  logic [BUSWIDTH-1:0] B,
   input  logic                load,
   input  logic                sel,
   output logic [BUSWIDTH-1:0] C_out
);

   elem_t a00, a01, a10, a11;
   elem_t b00, b01, b10, b11;
   mat_t  t_add, t_sub, s_sub;

   elem_t t_d [7];
   elem_t s_d [7];
   elem_t t_q [7];
   elem_t s_q [7];
   elem_t m   [7];

   logic  sel_p1_q, sel_p2_q, sel_p3_q;
   mat_t  c_d, c_q;
   mat_t  c_out_d, c_out_q;

   always_comb begin
      a00 = mat_el(A, E00);
      a01 = mat_el(A, E01);
      a10 = mat_el(A, E10);
      a11 = mat_el(A, E11);
      b00 = mat_el(B, E00);
      b10 = mat_el(B, E10);
      // Vector mode replicates column 0 so the unused products collapse cleanly.
      b01 = sel ? b00 : mat_el(B, E01);
      b11 = sel ? b10 : mat_el(B, E11);

      t_add = mat_add(mat_pack(a00, a10, a00, b00), mat_pack(a11, a11, a01, b11));
      t_sub = mat_sub(mat_pack(a10, a01, b01, b10), mat_pack(a00, a11, b11, b00));
      s_sub = t_sub;

      t_d[0] = mat_el(t_add, E00);
      t_d[1] = mat_el(t_add, E01);
      t_d[2] = a00;
      t_d[3] = a11;
      t_d[4] = mat_el(t_add, E10);
      t_d[5] = mat_el(t_sub, E00);
      t_d[6] = mat_el(t_sub, E01);

      s_d[0] = mat_el(t_add, E11);
      s_d[1] = b00;
      s_d[2] = mat_el(s_sub, E10);
      s_d[3] = mat_el(s_sub, E11);
      s_d[4] = b11;
      s_d[5] = b00 + b01;
      s_d[6] = b10 + b11;

      if (sel) begin
         t_d[0] = '0;
         t_d[5] = '0;
         t_d[6] = '0;
         s_d[0] = '0;
         s_d[5] = '0;
         s_d[6] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 7; i++) begin
            t_q[i] <= '0;
            s_q[i] <= '0;
         end
         sel_p1_q <= 1'b0;
      end else if (load) begin
         t_q      <= t_d;
         s_q      <= s_d;
         sel_p1_q <= sel;
      end
   end

   for (genvar g = 0; g < 7; g++) begin : g_mul
      smm0_elem_mul #(.DATAWIDTH(DATAWIDTH)) u_mul (
         .clk_i (clk),
         .rst_i (rst),
         .a_i   (t_q[g]),
         .b_i   (s_q[g]),
         .p_o   (m[g])
      );
   end

   // Lanes ordered (C00, C01, C10, C11): C = p + q + r - u.
   always_comb begin
      c_d = mat_sub(mat_add(mat_add(mat_pack(m[0], m[2], m[1], m[0]),
                                    mat_pack(m[3], m[4], m[3], m[2])),
                            mat_pack(m[6], '0, '0, m[5])),
                    mat_pack(m[4], '0, '0, m[1]));
      if (sel_p2_q) begin
         c_d[E00 +: DATAWIDTH] = '0;
         c_d[E11 +: DATAWIDTH] = '0;
      end
   end

   always_comb begin
      c_out_d = c_q;
      if (sel_p3_q) begin
         c_out_d = mat_pack(mat_el(c_q, E01), '0, mat_el(c_q, E10), '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_p2_q <= 1'b0;
         sel_p3_q <= 1'b0;
         c_q      <= '0;
         c_out_q  <= '0;
      end else begin
         sel_p2_q <= sel_p1_q;
         sel_p3_q <= sel_p2_q;
         c_q      <= c_d;
         c_out_q  <= c_out_d;
      end
   end

   assign C_out = c_out_q;

endmodule

// File: tb/tb_smm0.sv
// Bench for smm0: plain 2x2 matrix-product model with a 3-edge latency queue,
// checked every cycle, plus literal results for the hand-worked cases.
module tb_smm0;

   logic         clk;
   logic         rst;
   logic [127:0] A;
   logic [127:0] B;
   logic         load;
   logic         sel;
   logic [127:0] C_out;

   int vectors;
   int misses;
   logic chk_en;

   logic [127:0] exp_q[$];
   logic [127:0] held;
   logic [127:0] exp_cout;

   smm0 dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .load  (load),
      .sel   (sel),
      .C_out (C_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ordinary matrix product modulo 2^32; vector mode keeps column 0 only.
   function automatic logic [127:0] ref_mul(logic [127:0] a, logic [127:0] b, logic s);
      logic [31:0] am [2][2];
      logic [31:0] bm [2][2];
      logic [31:0] cm [2][2];
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            am[i][j] = a[(2*i+j)*32 +: 32];
            bm[i][j] = b[(2*i+j)*32 +: 32];
         end
      end
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            cm[i][j] = 32'd0;
            if (!(s && j == 1)) begin
               for (int k = 0; k < 2; k++) begin
                  cm[i][j] = cm[i][j] + am[i][k] * bm[k][j];
               end
            end
         end
      end
      return {cm[1][1], cm[1][0], cm[0][1], cm[0][0]};
   endfunction

   function automatic logic [127:0] pk(int e00, int e01, int e10, int e11);
      logic [31:0] x00, x01, x10, x11;
      x00 = e00;
      x01 = e01;
      x10 = e10;
      x11 = e11;
      return {x11, x10, x01, x00};
   endfunction

   function automatic logic [127:0] rnd_mat();
      logic [127:0] m;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 1) m[i*32 +: 32] = $urandom;
         else m[i*32 +: 32] = $urandom_range(0, 31) - 16;
      end
      return m;
   endfunction

   task automatic step(input logic r, input logic ld, input logic s,
                       input logic [127:0] a, input logic [127:0] b);
      @(negedge clk);
      rst  = r;
      load = ld;
      sel  = s;
      A    = a;
      B    = b;
      @(posedge clk);
      #1;
      if (r) begin
         held  = '0;
         exp_q = '{128'd0, 128'd0, 128'd0};
         exp_cout = '0;
      end else begin
         exp_cout = exp_q.pop_front();
         if (ld) held = ref_mul(a, b, s);
         exp_q.push_back(held);
      end
   endtask

   task automatic idle_rand();
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd_mat(), rnd_mat());
   endtask

   task automatic check(input string name, input logic [127:0] want);
      vectors++;
      if (C_out !== want) begin
         misses++;
         $display("FAIL %s: got %h want %h", name, C_out, want);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (C_out !== exp_cout) begin
            misses++;
            $display("FAIL cout @%0t: got %h want %h", $time, C_out, exp_cout);
         end
      end
   end

   localparam logic [127:0] LIT_BASIC  = 128'h00000032_0000002B_00000016_00000013;
   localparam logic [127:0] LIT_VEC    = 128'h00000000_0000002B_00000000_00000013;
   localparam logic [127:0] LIT_SIGNED = 128'hFFFFFFFC_00000003_00000002_FFFFFFFF;

   initial begin
      logic [127:0] a1, b1, as, bi, ao, bo;
      vectors  = 0;
      misses   = 0;
      chk_en   = 1'b0;
      rst      = 1'b1;
      load     = 1'b0;
      sel      = 1'b0;
      A        = '0;
      B        = '0;
      held     = '0;
      exp_cout = '0;
      exp_q    = '{128'd0, 128'd0, 128'd0};

      a1 = pk(1, 2, 3, 4);
      b1 = pk(5, 6, 7, 8);
      as = pk(-1, 2, 3, -4);
      bi = pk(1, 0, 0, 1);
      ao = pk(32'h00010000, 0, 0, 0);
      bo = pk(32'h00010000, 0, 0, 0);

      step(1'b1, 1'b0, 1'b0, '0, '0);
      chk_en = 1'b1;
      step(1'b1, 1'b1, 1'b0, a1, b1);
      check("reset", 128'd0);

      step(1'b0, 1'b1, 1'b0, a1, b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, a1, b1);
      check("basic", LIT_BASIC);

      step(1'b0, 1'b1, 1'b1, a1, b1);
      repeat (3) step(1'b0, 1'b0, 1'b1, a1, b1);
      check("vector", LIT_VEC);

      step(1'b0, 1'b1, 1'b0, as, bi);
      repeat (3) step(1'b0, 1'b0, 1'b0, as, bi);
      check("signed", LIT_SIGNED);

      step(1'b0, 1'b1, 1'b0, ao, bo);
      repeat (3) step(1'b0, 1'b0, 1'b0, ao, bo);
      check("overflow", 128'd0);

      step(1'b0, 1'b1, 1'b0, a1, b1);
      step(1'b0, 1'b1, 1'b0, as, bi);
      idle_rand();
      idle_rand();
      check("b2b_first", LIT_BASIC);
      idle_rand();
      check("b2b_second", LIT_SIGNED);
      repeat (4) idle_rand();
      check("hold", LIT_SIGNED);

      step(1'b0, 1'b1, 1'b0, a1, b1);
      step(1'b1, 1'b0, 1'b0, a1, b1);
      check("rst_clear", 128'd0);
      repeat (5) step(1'b0, 1'b0, 1'b0, a1, b1);
      check("rst_after", 128'd0);

      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)), rnd_mat(), rnd_mat());
      end
      repeat (4) idle_rand();

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
